branch_predictor_gshare: RTL

Parametrised successor to the 2-bit branch predictor. It indexes a pattern history table (PHT) of saturating counters with PC XOR global history (gshare). It keeps a checkpoint FIFO of in-flight branches so that a mispredict restores history exactly. It broadcasts a single flush plus the redirect address to IF, LSB, ROB, RS, Register and CDB, and keeps commit/mispredict statistics.

---
 rtl/bp_pkg.sv | 34 +++
 rtl/bp_ckpt_fifo.sv | 60 ++++++
 rtl/branch_predictor_gshare.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare branch predictor.
// Counter sizing helpers take the counter width because the PHT width is a module parameter.
package bp_pkg;

    localparam int IDX_MAX_W = 16;
    localparam int GHR_MAX_W = 16;
    localparam int CNT_W_DEF = 2;

    typedef struct packed {
        logic [31:0]          next_addr;
        logic [31:0]          jump_addr;
        logic [IDX_MAX_W-1:0] idx;
        logic                 pred;
        logic [GHR_MAX_W-1:0] ghr;
    } bp_entry_t;

    typedef enum logic [0:0] {
        NORMAL  = 1'b0,
        COOLING = 1'b1
    } bp_state_e;

    // Weakly not-taken: one below the taken threshold.
    function automatic int cnt_init(input int cnt_w);
        return (1 << (cnt_w - 1)) - 1;
    endfunction

    function automatic int cnt_taken_thresh(input int cnt_w);
        return 1 << (cnt_w - 1);
    endfunction

    localparam int CNT_INIT_DEF  = (1 << (CNT_W_DEF - 1)) - 1;
    localparam int CNT_TAKEN_DEF = 1 << (CNT_W_DEF - 1);

endpackage

// File: rtl/bp_ckpt_fifo.sv
// Circular checkpoint FIFO of in-flight branches; clear drops every entry at once.
// Callers only push when not full and pop when not empty; both are re-checked here.
module bp_ckpt_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH_W = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  logic      clear,
    input  bp_entry_t push_data,
    output bp_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int DEPTH = 2 ** DEPTH_W;

    bp_entry_t            mem [DEPTH];
    logic [DEPTH_W-1:0]   wr_ptr;
    logic [DEPTH_W-1:0]   rd_ptr;
    logic [DEPTH_W:0]     count;
    logic                 push_ok;
    logic                 pop_ok;

    assign full    = (count == (DEPTH_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (DEPTH_W + 1)'(push_ok) - (DEPTH_W + 1)'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !clear && push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/branch_predictor_gshare.sv
// Gshare predictor: PHT indexed by PC ^ speculative history, with checkpointed
// in-flight branches so a mispredict restores history from the architectural copy.
//
// state   | meaning
// --------+-----------------------------------------------------------
// NORMAL  | asks and commits accepted
// COOLING | cycle after a flush; asks and commits ignored
module branch_predictor_gshare
    import bp_pkg::*;
#(
    parameter int PHT_IDX_W    = 6,
    parameter int GHR_W        = 4,
    parameter int CNT_W        = 2,
    parameter int FIFO_DEPTH_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        ask_predictor,
    input  logic [31:0] now_ins_addr,
    input  logic [31:0] jump_addr_from_if,
    input  logic [31:0] next_addr_from_if,
    output logic        jump,
    output logic        predictor_sgn_rdy,
    output logic        predictor_full,
    input  logic        branch_commit,
    input  logic        branch_jump,
    output logic        flush,
    output logic [31:0] addr_to_if,
    output logic [31:0] commit_cnt,
    output logic [31:0] mispredict_cnt
);

    localparam int                PHT_N    = 2 ** PHT_IDX_W;
    localparam int                GHR_S    = (GHR_W > 0) ? GHR_W : 1;
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(cnt_init(CNT_W));
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    bp_state_e              state;
    logic [GHR_S-1:0]       spec_ghr;
    logic [GHR_S-1:0]       arch_ghr;
    logic [CNT_W-1:0]       pht [PHT_N];

    logic [PHT_IDX_W-1:0]   ghr_ext;
    logic [PHT_IDX_W-1:0]   ask_idx;
    logic [PHT_IDX_W-1:0]   upd_idx;
    logic                   pred_dir;
    logic                   ask_ok;
    logic                   commit_ok;
    logic                   mispredict;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    bp_entry_t              push_data;
    bp_entry_t              head;
    logic                   unused_bits;

    // With zero history bits the register exists but stays at zero (bimodal).
    function automatic logic [GHR_S-1:0] ghr_shift(input logic [GHR_S-1:0] g, input logic b);
        if (GHR_W == 0) begin
            return '0;
        end
        return GHR_S'({g, b});
    endfunction

    always_comb begin
        ghr_ext = '0;
        if (GHR_W > 0) begin
            ghr_ext = PHT_IDX_W'(spec_ghr);
        end
    end

    assign ask_idx  = now_ins_addr[PHT_IDX_W+1:2] ^ ghr_ext;
    assign pred_dir = pht[ask_idx][CNT_W-1];
    assign upd_idx  = head.idx[PHT_IDX_W-1:0];

    assign predictor_full = fifo_full;
    assign ask_ok     = rdy && ask_predictor && !fifo_full && (state == NORMAL);
    assign commit_ok  = rdy && branch_commit && !fifo_empty && (state == NORMAL);
    assign mispredict = commit_ok && (head.pred != branch_jump);
    // A mispredict squashes a same-cycle ask along with everything queued.
    assign fifo_push  = ask_ok && !mispredict;
    assign fifo_pop   = commit_ok && !mispredict;

    always_comb begin
        push_data           = '0;
        push_data.next_addr = next_addr_from_if;
        push_data.jump_addr = jump_addr_from_if;
        push_data.idx       = IDX_MAX_W'(ask_idx);
        push_data.pred      = pred_dir;
        push_data.ghr       = GHR_MAX_W'(spec_ghr);
    end

    assign unused_bits = ^{head, now_ins_addr};

    bp_ckpt_fifo #(
        .DEPTH_W (FIFO_DEPTH_W)
    ) u_ckpt_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .clear     (mispredict),
        .push_data (push_data),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= NORMAL;
            spec_ghr          <= '0;
            arch_ghr          <= '0;
            jump              <= 1'b0;
            predictor_sgn_rdy <= 1'b0;
            flush             <= 1'b0;
            addr_to_if        <= '0;
            commit_cnt        <= '0;
            mispredict_cnt    <= '0;
            for (int i = 0; i < PHT_N; i++) begin
                pht[i] <= CNT_INIT;
            end
        end else if (rdy) begin
            predictor_sgn_rdy <= fifo_push;
            if (fifo_push) begin
                jump <= pred_dir;
            end

            flush <= mispredict;
            if (mispredict) begin
                addr_to_if <= branch_jump ? head.jump_addr : head.next_addr;
            end

            case (state)
                NORMAL:  if (mispredict) state <= COOLING;
                COOLING: state <= NORMAL;
                default: state <= NORMAL;
            endcase

            if (commit_ok) begin
                if (branch_jump) begin
                    if (pht[upd_idx] != CNT_MAX) begin
                        pht[upd_idx] <= pht[upd_idx] + 1'b1;
                    end
                end else if (pht[upd_idx] != '0) begin
                    pht[upd_idx] <= pht[upd_idx] - 1'b1;
                end
                arch_ghr   <= ghr_shift(arch_ghr, branch_jump);
                commit_cnt <= commit_cnt + 32'd1;
            end

            if (mispredict) begin
                mispredict_cnt <= mispredict_cnt + 32'd1;
                spec_ghr       <= ghr_shift(arch_ghr, branch_jump);
            end else if (fifo_push) begin
                spec_ghr <= ghr_shift(spec_ghr, pred_dir);
            end
        end
    end

endmodule
